// File: rtl/wb_stage_if.sv
// Pipeline-wide width/type package and the memory-stage -> writeback handshake bus.
// The memory stage uses the master modport; wb_stage uses the slave modport.
package wb_pkg;
  localparam int XLEN = 32;

  typedef struct packed {
    logic [4:0]      rd_addr;
    logic [XLEN-1:0] data;
  } wb_sig_t;
endpackage

interface wb_stage_if;
  logic                     in_valid;
  logic                     in_ready;
  logic [4:0]               in_rd_addr;
  logic [wb_pkg::XLEN-1:0]  in_result;
  logic                     in_is_load;
  logic [2:0]               in_funct3;
  logic [1:0]               in_addr_lo;

  modport master (
    output in_valid, in_rd_addr, in_result, in_is_load, in_funct3, in_addr_lo,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_rd_addr, in_result, in_is_load, in_funct3, in_addr_lo,
    output in_ready
  );
endinterface

// File: rtl/wb_stage.sv
// Writeback stage: registers one rf write per retired instruction, waits on load data, counts retires.
// Optional WB_BYPASS_EN adds a combinational writeback-to-decode forwarding path.
module wb_stage
  import wb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  wb_stage_if.slave         in_if,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata,
`ifdef WB_BYPASS_EN
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  input  logic [XLEN-1:0]   rf_rs1_data,
  input  logic [XLEN-1:0]   rf_rs2_data,
  output logic [XLEN-1:0]   fwd_rs1_data,
  output logic [XLEN-1:0]   fwd_rs2_data,
`endif
  output wb_sig_t           signals_out,
  output logic              stall,
  output logic [31:0]       retire_count
);

  typedef enum logic {IDLE, WAIT_LOAD} state_t;

  state_t      state_q, state_d;
  wb_sig_t     wb_q, wb_d;
  logic [31:0] retire_q, retire_d;
  logic [4:0]  ld_rd_q, ld_rd_d;
  logic [2:0]  ld_funct3_q, ld_funct3_d;
  logic [1:0]  ld_addr_lo_q, ld_addr_lo_d;
  logic        accept;
  logic        commit;

  // addr_lo[0] is ignored for halves: misaligned halves read the enclosing aligned half.
  function automatic logic [XLEN-1:0] load_extract(input logic [2:0]  funct3,
                                                   input logic [1:0]  addr_lo,
                                                   input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{addr_lo, 3'b000} +: 8];
    h = word[{addr_lo[1], 4'b0000} +: 16];
    case (funct3)
      3'b000:  load_extract = {{24{b[7]}}, b};
      3'b001:  load_extract = {{16{h[15]}}, h};
      3'b100:  load_extract = {24'd0, b};
      3'b101:  load_extract = {16'd0, h};
      default: load_extract = word;
    endcase
  endfunction

  assign in_if.in_ready = (state_q == IDLE);
  assign stall          = (state_q != IDLE);
  assign accept         = in_if.in_valid && in_if.in_ready;

  always_comb begin
    state_d      = state_q;
    wb_d         = '0;
    ld_rd_d      = ld_rd_q;
    ld_funct3_d  = ld_funct3_q;
    ld_addr_lo_d = ld_addr_lo_q;
    commit       = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (!in_if.in_is_load) begin
            commit = 1'b1;
            wb_d   = '{rd_addr: in_if.in_rd_addr, data: in_if.in_result};
          end else if (mem_rvalid) begin
            commit = 1'b1;
            wb_d   = '{rd_addr: in_if.in_rd_addr,
                       data: load_extract(in_if.in_funct3, in_if.in_addr_lo, mem_rdata)};
          end else begin
            ld_rd_d      = in_if.in_rd_addr;
            ld_funct3_d  = in_if.in_funct3;
            ld_addr_lo_d = in_if.in_addr_lo;
            state_d      = WAIT_LOAD;
          end
        end
      end
      WAIT_LOAD: begin
        if (mem_rvalid) begin
          commit  = 1'b1;
          wb_d    = '{rd_addr: ld_rd_q,
                      data: load_extract(ld_funct3_q, ld_addr_lo_q, mem_rdata)};
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    retire_d = commit ? retire_q + 32'd1 : retire_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      wb_q         <= '0;
      retire_q     <= '0;
      ld_rd_q      <= '0;
      ld_funct3_q  <= '0;
      ld_addr_lo_q <= '0;
    end else begin
      state_q      <= state_d;
      wb_q         <= wb_d;
      retire_q     <= retire_d;
      ld_rd_q      <= ld_rd_d;
      ld_funct3_q  <= ld_funct3_d;
      ld_addr_lo_q <= ld_addr_lo_d;
    end
  end

  assign signals_out  = wb_q;
  assign retire_count = retire_q;

`ifdef WB_BYPASS_EN
  // rf returns the old value on a same-cycle write-then-read; forward the pending write instead.
  assign fwd_rs1_data = (wb_q.rd_addr != 5'd0 && wb_q.rd_addr == rs1_addr) ? wb_q.data : rf_rs1_data;
  assign fwd_rs2_data = (wb_q.rd_addr != 5'd0 && wb_q.rd_addr == rs2_addr) ? wb_q.data : rf_rs2_data;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Directed self-checking bench for wb_stage: ALU commits, load hits/waits, x0, stale rvalid, reset mid-load.
module tb_wb_stage;
  import wb_pkg::*;

  logic        clk;
  logic        rst;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  wb_sig_t     signals_out;
  logic        stall;
  logic [31:0] retire_count;
`ifdef WB_BYPASS_EN
  logic [4:0]      rs1_addr, rs2_addr;
  logic [XLEN-1:0] rf_rs1_data, rf_rs2_data;
  logic [XLEN-1:0] fwd_rs1_data, fwd_rs2_data;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] exp_retire;

  wb_stage_if in_if();

  wb_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_if        (in_if.slave),
    .mem_rvalid   (mem_rvalid),
    .mem_rdata    (mem_rdata),
`ifdef WB_BYPASS_EN
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rf_rs1_data  (rf_rs1_data),
    .rf_rs2_data  (rf_rs2_data),
    .fwd_rs1_data (fwd_rs1_data),
    .fwd_rs2_data (fwd_rs2_data),
`endif
    .signals_out  (signals_out),
    .stall        (stall),
    .retire_count (retire_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_alu(input logic [4:0] rd, input logic [31:0] res);
    in_if.in_valid   = 1'b1;
    in_if.in_is_load = 1'b0;
    in_if.in_rd_addr = rd;
    in_if.in_result  = res;
    in_if.in_funct3  = 3'b000;
    in_if.in_addr_lo = 2'b00;
  endtask

  task automatic drive_load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] lo);
    in_if.in_valid   = 1'b1;
    in_if.in_is_load = 1'b1;
    in_if.in_rd_addr = rd;
    in_if.in_result  = 32'hDEAD_0000;
    in_if.in_funct3  = f3;
    in_if.in_addr_lo = lo;
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [1:0]  lo;
    logic [31:0] word;
    logic [31:0] exp;
  } ld_vec_t;

  ld_vec_t vecs[7];

  initial begin
    vecs[0] = '{3'b000, 2'd2, 32'h0080_0000, 32'hFFFF_FF80}; // LB sign
    vecs[1] = '{3'b100, 2'd2, 32'h0080_0000, 32'h0000_0080}; // LBU
    vecs[2] = '{3'b000, 2'd3, 32'h7F00_0000, 32'h0000_007F}; // LB positive, top byte
    vecs[3] = '{3'b001, 2'd0, 32'h0000_8001, 32'hFFFF_8001}; // LH low half
    vecs[4] = '{3'b001, 2'd3, 32'h8001_0000, 32'hFFFF_8001}; // LH, addr_lo[0] ignored
    vecs[5] = '{3'b010, 2'd1, 32'hDEAD_BEEF, 32'hDEAD_BEEF}; // LW
    vecs[6] = '{3'b111, 2'd2, 32'h1234_5678, 32'h1234_5678}; // undefined funct3 -> word

    rst              = 1'b1;
    mem_rvalid       = 1'b0;
    mem_rdata        = '0;
    in_if.in_valid   = 1'b0;
    in_if.in_is_load = 1'b0;
    in_if.in_rd_addr = '0;
    in_if.in_result  = '0;
    in_if.in_funct3  = '0;
    in_if.in_addr_lo = '0;
`ifdef WB_BYPASS_EN
    rs1_addr    = '0;
    rs2_addr    = '0;
    rf_rs1_data = '0;
    rf_rs2_data = '0;
`endif
    exp_retire = 0;

    tick;
    tick;
    check_eq("reset rd_addr", 32'(signals_out.rd_addr), 32'd0);
    check_eq("reset data", signals_out.data, 32'd0);
    check_eq("reset retire", retire_count, 32'd0);
    check_eq("reset in_ready", 32'(in_if.in_ready), 32'd1);
    check_eq("reset stall", 32'(stall), 32'd0);
    rst = 1'b0;

    // ALU result, latency 1, then back to no-write
    drive_alu(5'd5, 32'h0000_1234);
    tick;
    in_if.in_valid = 1'b0;
    exp_retire++;
    check_eq("alu rd_addr", 32'(signals_out.rd_addr), 32'd5);
    check_eq("alu data", signals_out.data, 32'h0000_1234);
    check_eq("alu retire", retire_count, exp_retire);
    tick;
    check_eq("alu idle rd_addr", 32'(signals_out.rd_addr), 32'd0);
    check_eq("alu idle retire", retire_count, exp_retire);

    // Load hits with rvalid in the accept cycle
    for (int i = 0; i < 7; i++) begin
      drive_load(5'd3, vecs[i].f3, vecs[i].lo);
      mem_rvalid = 1'b1;
      mem_rdata  = vecs[i].word;
      tick;
      in_if.in_valid = 1'b0;
      mem_rvalid     = 1'b0;
      exp_retire++;
      check_eq($sformatf("hit%0d rd_addr", i), 32'(signals_out.rd_addr), 32'd3);
      check_eq($sformatf("hit%0d data", i), signals_out.data, vecs[i].exp);
      check_eq($sformatf("hit%0d retire", i), retire_count, exp_retire);
    end

    // LHU waits 4 cycles; next instruction is held upstream meanwhile
    drive_load(5'd7, 3'b101, 2'd2);
    tick;
    drive_alu(5'd10, 32'h0000_0055);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("wait%0d in_ready", i), 32'(in_if.in_ready), 32'd0);
      check_eq($sformatf("wait%0d stall", i), 32'(stall), 32'd1);
      check_eq($sformatf("wait%0d rd_addr", i), 32'(signals_out.rd_addr), 32'd0);
      if (i < 3) tick;
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hBEEF_0000;
    tick;
    mem_rvalid = 1'b0;
    exp_retire++;
    check_eq("wait commit rd_addr", 32'(signals_out.rd_addr), 32'd7);
    check_eq("wait commit data", signals_out.data, 32'h0000_BEEF);
    check_eq("wait commit retire", retire_count, exp_retire);
    check_eq("wait done in_ready", 32'(in_if.in_ready), 32'd1);
    tick;
    in_if.in_valid = 1'b0;
    exp_retire++;
    check_eq("post-wait alu rd_addr", 32'(signals_out.rd_addr), 32'd10);
    check_eq("post-wait alu data", signals_out.data, 32'h0000_0055);
    check_eq("post-wait retire", retire_count, exp_retire);

    // Stale rvalid in IDLE with nothing accepted
    mem_rvalid = 1'b1;
    mem_rdata  = 32'hFFFF_FFFF;
    tick;
    mem_rvalid = 1'b0;
    check_eq("stale rd_addr", 32'(signals_out.rd_addr), 32'd0);
    check_eq("stale retire", retire_count, exp_retire);

    // x0 destination still retires
    drive_alu(5'd0, 32'h0000_FFFF);
    tick;
    in_if.in_valid = 1'b0;
    exp_retire++;
    check_eq("x0 rd_addr", 32'(signals_out.rd_addr), 32'd0);
    check_eq("x0 retire", retire_count, exp_retire);

`ifdef WB_BYPASS_EN
    drive_alu(5'd9, 32'h0000_A5A5);
    tick;
    in_if.in_valid = 1'b0;
    exp_retire++;
    rs1_addr    = 5'd9;
    rf_rs1_data = 32'h0;
    rs2_addr    = 5'd4;
    rf_rs2_data = 32'h0000_2222;
    #1;
    check_eq("fwd rs1 hit", fwd_rs1_data, 32'h0000_A5A5);
    check_eq("fwd rs2 miss", fwd_rs2_data, 32'h0000_2222);
    rs1_addr    = 5'd0;
    rf_rs1_data = 32'h0000_1111;
    #1;
    check_eq("fwd rs1 x0", fwd_rs1_data, 32'h0000_1111);
    tick;
`endif

    // Reset while a load is pending, with rvalid arriving during and after reset
    drive_load(5'd12, 3'b010, 2'd0);
    tick;
    in_if.in_valid = 1'b0;
    check_eq("pre-reset in_ready", 32'(in_if.in_ready), 32'd0);
    rst        = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1357_9BDF;
    tick;
    rst = 1'b0;
    tick;
    mem_rvalid = 1'b0;
    check_eq("rst-wait rd_addr", 32'(signals_out.rd_addr), 32'd0);
    check_eq("rst-wait retire", retire_count, 32'd0);
    check_eq("rst-wait in_ready", 32'(in_if.in_ready), 32'd1);
    tick;
    check_eq("rst-wait later rd_addr", 32'(signals_out.rd_addr), 32'd0);
    check_eq("rst-wait later retire", retire_count, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
